// File: rtl/tnn_feature_packer.sv
// rtl/tnn_feature_packer.sv - packs six quantized feature samples into one classifier frame
// Define TNN_QUANT_ROUND_EN for round-to-nearest quantization; default build truncates.
module tnn_feature_packer #(
  parameter int FEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2:0]        input_a,
  output logic [2:0]        input_b,
  output logic [2:0]        input_c,
  output logic [2:0]        input_d,
  output logic [2:0]        input_e,
  output logic [2:0]        input_f,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam int SHIFT = FEAT_W - 3;

  state_t      state_q;
  logic        live_q;
  logic [2:0]  idx_q;
  logic [2:0]  slot_q [6];
  logic        m_valid_q;
  logic        frame_err_q;
  logic [7:0]  err_cnt_q;
  logic [7:0]  err_cnt_d;

  logic [FEAT_W:0] wide;
  logic [FEAT_W:0] scaled;
  logic [2:0]      quant_d;
  logic            accept;

  // Both modes share the widened saturating path; truncation simply never exceeds 7.
  always_comb begin
`ifdef TNN_QUANT_ROUND_EN
    wide = {1'b0, s_data} + (FEAT_W+1)'(1 << (FEAT_W - 4));
`else
    wide = {1'b0, s_data};
`endif
    scaled  = wide >> SHIFT;
    quant_d = (scaled > (FEAT_W+1)'(7)) ? 3'd7 : scaled[2:0];
  end

  // live_q keeps s_ready low until the first edge after reset release.
  assign s_ready   = live_q && (state_q == FILL);
  assign accept    = s_valid && s_ready;
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      live_q      <= 1'b0;
      idx_q       <= 3'd0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
      for (int i = 0; i < 6; i++) slot_q[i] <= 3'd0;
    end else begin
      live_q      <= 1'b1;
      frame_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            slot_q[idx_q] <= quant_d;
            if (s_last && idx_q == 3'd5) begin
              state_q   <= HOLD;
              m_valid_q <= 1'b1;
              idx_q     <= 3'd0;
            end else if (s_last || idx_q == 3'd5) begin
              frame_err_q <= 1'b1;
              err_cnt_q   <= err_cnt_d;
              idx_q       <= 3'd0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            state_q   <= FILL;
            m_valid_q <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign input_a   = slot_q[0];
  assign input_b   = slot_q[1];
  assign input_c   = slot_q[2];
  assign input_d   = slot_q[3];
  assign input_e   = slot_q[4];
  assign input_f   = slot_q[5];

endmodule

// File: tb/tb_tnn_feature_packer.sv
// tb/tb_tnn_feature_packer.sv - self-checking bench for tnn_feature_packer
// Expected values follow TNN_QUANT_ROUND_EN the same way the design build does.
module tb_tnn_feature_packer;

  localparam int FEAT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [2:0]  input_a, input_b, input_c, input_d, input_e, input_f;
  logic        frame_err;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int model_err = 0;

  typedef struct packed {
    logic [47:0] d;
    logic [17:0] e;
  } vec_t;

  vec_t tbl [4];

  tnn_feature_packer #(.FEAT_W(FEAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .input_a(input_a), .input_b(input_b), .input_c(input_c),
    .input_d(input_d), .input_e(input_e), .input_f(input_f),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] q_model(input int d);
    int r;
`ifdef TNN_QUANT_ROUND_EN
    r = (d + (1 << (FEAT_W - 4))) / (1 << (FEAT_W - 3));
`else
    r = d / (1 << (FEAT_W - 3));
`endif
    if (r > 7) r = 7;
    return 3'(r);
  endfunction

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (!s_ready) check("s_ready_wait", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic logic [17:0] outs();
    return {input_f, input_e, input_d, input_c, input_b, input_a};
  endfunction

  task automatic load_frame(input logic [47:0] d);
    for (int i = 0; i < 6; i++) send(d[8*i +: 8], i == 5);
  endtask

  task automatic check_frame(input logic [47:0] d, input logic [17:0] e, input string tag);
    load_frame(d);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      logic [17:0] o;
      o = outs();
      check($sformatf("%s_slot%0d", tag, i), 32'(o[3*i +: 3]), 32'(e[3*i +: 3]));
    end
  endtask

  task automatic consume(input string tag);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check({tag, "_consumed_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_consumed_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic [47:0] rd;
    logic [17:0] re;
    logic [17:0] held;

    tbl[0].d = {8'hFF, 8'hE0, 8'h60, 8'h40, 8'h20, 8'h00};
    tbl[0].e = {3'd7, 3'd7, 3'd3, 3'd2, 3'd1, 3'd0};
    tbl[1].d = {8'hFF, 8'hF0, 8'hEF, 8'h30, 8'h2F, 8'h10};
    tbl[2].d = {8'h1F, 8'h1F, 8'h00, 8'hFF, 8'h00, 8'h1F};
    tbl[3].d = {8'h7F, 8'h5F, 8'hDF, 8'hCF, 8'hBF, 8'h9F};
`ifdef TNN_QUANT_ROUND_EN
    tbl[1].e = {3'd7, 3'd7, 3'd7, 3'd2, 3'd1, 3'd1};
    tbl[2].e = {3'd1, 3'd1, 3'd0, 3'd7, 3'd0, 3'd1};
    tbl[3].e = {3'd4, 3'd3, 3'd7, 3'd6, 3'd6, 3'd5};
`else
    tbl[1].e = {3'd7, 3'd7, 3'd7, 3'd1, 3'd1, 3'd0};
    tbl[2].e = {3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0};
    tbl[3].e = {3'd3, 3'd2, 3'd6, 3'd6, 3'd5, 3'd4};
`endif

    // reset state
    #3;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_outs", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_s_ready_before_edge", 32'(s_ready), 32'd0);
    step();
    check("release_s_ready_after_edge", 32'(s_ready), 32'd1);

    // table vectors
    for (int v = 0; v < 4; v++) begin
      check_frame(tbl[v].d, tbl[v].e, $sformatf("tbl%0d", v));
      consume($sformatf("tbl%0d", v));
    end

    // hold with back-pressure and junk input
    check_frame(tbl[3].d, tbl[3].e, "hold");
    held = tbl[3].e;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      step();
      check("hold_m_valid", 32'(m_valid), 32'd1);
      check("hold_s_ready", 32'(s_ready), 32'd0);
      check("hold_outs", 32'(outs()), 32'(held));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    consume("hold");
    check_frame(tbl[0].d, tbl[0].e, "after_hold");
    consume("after_hold");

    // early s_last
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    model_err++;
    check("early_last_frame_err", 32'(frame_err), 32'd1);
    check("early_last_err_cnt", 32'(err_cnt), 32'(model_err));
    check("early_last_m_valid", 32'(m_valid), 32'd0);
    step();
    check("early_last_pulse_width", 32'(frame_err), 32'd0);
    check_frame(tbl[1].d, tbl[1].e, "after_early");
    consume("after_early");

    // missing s_last on the sixth sample
    for (int i = 0; i < 6; i++) send(8'(i * 40), 1'b0);
    model_err++;
    check("missing_last_frame_err", 32'(frame_err), 32'd1);
    check("missing_last_err_cnt", 32'(err_cnt), 32'(model_err));
    check("missing_last_m_valid", 32'(m_valid), 32'd0);

    // randomized frames against the quantization model
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        int len;
        len = int'($urandom_range(1, 5));
        for (int i = 0; i < len; i++) send(8'($urandom), i == len - 1);
        model_err++;
        check("rand_short_frame_err", 32'(frame_err), 32'd1);
        check("rand_short_err_cnt", 32'(err_cnt), 32'(sat(model_err)));
      end else begin
        for (int i = 0; i < 6; i++) begin
          rd[8*i +: 8] = 8'($urandom);
          re[3*i +: 3] = q_model(int'(rd[8*i +: 8]));
        end
        check_frame(rd, re, "rand");
        repeat ($urandom_range(0, 3)) begin
          step();
          check("rand_wait_outs", 32'(outs()), 32'(re));
        end
        consume("rand");
        check("rand_err_cnt", 32'(err_cnt), 32'(sat(model_err)));
      end
    end

    // saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 1'b1);
      model_err++;
      check("sat_err_cnt", 32'(err_cnt), 32'(sat(model_err)));
    end
    check("sat_final", 32'(err_cnt), 32'd255);

    // reset mid-frame
    for (int i = 0; i < 4; i++) send(8'hF0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    check("midrst_outs", 32'(outs()), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("midrst_release_s_ready", 32'(s_ready), 32'd1);
    check("midrst_release_frame_err", 32'(frame_err), 32'd0);
    check_frame(tbl[2].d, tbl[2].e, "after_midrst");
    consume("after_midrst");

    // reset while holding a frame
    check_frame(tbl[1].d, tbl[1].e, "pre_holdrst");
    #2 rst_n = 1'b0;
    #1;
    check("holdrst_m_valid", 32'(m_valid), 32'd0);
    check("holdrst_frame_err", 32'(frame_err), 32'd0);
    check("holdrst_outs", 32'(outs()), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("holdrst_frame_err_after", 32'(frame_err), 32'd0);
    check("holdrst_err_cnt", 32'(err_cnt), 32'd0);
    check_frame(tbl[3].d, tbl[3].e, "after_holdrst");
    consume("after_holdrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tnn_feature_packer.md
TNN_FEATURE_PACKER -- requirements
Module: tnn_feature_packer

Interface
REQ-001 SHALL have parameter FEAT_W, default 8, giving the raw feature sample width; legal values are 4..16.
REQ-002 SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, width 1, reset; it is asynchronous and active-low.
REQ-004 SHALL have port s_valid, input, width 1, indicating a raw sample is offered.
REQ-005 SHALL have port s_ready, output, width 1, indicating the block accepts the offered sample.
REQ-006 SHALL have port s_data, input, width FEAT_W, the raw unsigned feature sample.
REQ-007 SHALL have port s_last, input, width 1, marking the sixth (final) sample of a frame.
REQ-008 SHALL have port m_valid, output, width 1, indicating a packed frame is presented.
REQ-009 SHALL have port m_ready, input, width 1, indicating the downstream classifier consumes the frame.
REQ-010 SHALL have ports input_a, input_b, input_c, input_d, input_e and input_f, each an output of width 3, carrying quantized features 0..5 in that order, for direct connection to the classifier inputs of the same names.
REQ-011 SHALL have port frame_err, output, width 1, a one-cycle pulse on a framing error.
REQ-012 SHALL have port err_cnt, output, width 8, a saturating framing-error count.

Function
REQ-013 SHALL implement two states: FILL, with s_ready=1, and HOLD, with s_ready=0 and m_valid=1.
REQ-014 SHALL treat a sample as accepted when s_valid and s_ready are both high on a clock edge.
REQ-015 SHALL, in FILL, on each accepted sample, write the quantized value into slot idx (0=a .. 5=f) and then increment idx.
REQ-016 SHALL, on acceptance with idx=5 and s_last=1, enter HOLD, so that m_valid rises in the cycle after the sixth acceptance (latency 1).
REQ-017 SHALL hold input_a..input_f stable while m_valid=1.
REQ-018 SHALL, in HOLD, when m_ready=1 on an edge, return to FILL with idx=0 and s_ready=1 in the next cycle; a new frame cannot be accepted in the same cycle the previous frame is consumed.
REQ-019 SHALL, on acceptance with s_last=1 and idx<5, pulse frame_err, discard the partial frame, set idx=0 and remain in FILL.
REQ-020 SHALL, on acceptance with idx=5 and s_last=0, pulse frame_err, discard the frame, set idx=0 and remain in FILL.
REQ-021 SHALL increment err_cnt on each frame_err pulse and saturate it at 255.
REQ-022 SHALL keep m_valid and all input_* outputs registered; the only combinational path permitted is from state to s_ready.
REQ-023 SHALL compute the quantization in FEAT_W+1 bits, with a result always in 0..7.

Reset
REQ-024 SHALL, while rst_n=0, immediately force: state=FILL, idx=0, s_ready=0, m_valid=0, input_a..input_f=0, frame_err=0, err_cnt=0.
REQ-025 SHALL raise s_ready on the first rising clk edge after rst_n deasserts.
REQ-026 SHALL, when reset is asserted mid-frame or in HOLD, drop the partial or held frame without producing a frame_err pulse.

Configuration
REQ-027 SHALL, when macro TNN_QUANT_ROUND_EN is defined, quantize as q = min(7, (s_data + 2^(FEAT_W-4)) >> (FEAT_W-3)), i.e. round-to-nearest with saturation.
REQ-028 SHALL, when TNN_QUANT_ROUND_EN is not defined, quantize as q = s_data[FEAT_W-1:FEAT_W-3], i.e. truncation; all other behaviour is identical.

Verification
REQ-029 SHALL pass this scenario: FEAT_W=8, truncation, samples 0x00,0x20,0x40,0x60,0xE0,0xFF with s_last on the 6th -> m_valid=1 one cycle later; a..f = 0,1,2,3,7,7.
REQ-030 SHALL pass this scenario: TNN_QUANT_ROUND_EN defined, samples 0x10,0x2F,0x30,0xEF,0xF0,0xFF -> a..f = 1,1,2,7,7,7.
REQ-031 SHALL pass this scenario: s_last on the 3rd sample -> frame_err pulses 1 cycle, err_cnt=1, no m_valid; the next 6 good samples produce one frame.
REQ-032 SHALL pass this scenario: frame held with m_ready=0 for 10 cycles -> outputs stable, s_ready=0, s_valid ignored; m_ready=1 -> m_valid=0 and s_ready=1 in the next cycle.
REQ-033 SHALL pass this scenario: 300 consecutive framing errors -> err_cnt saturates at 255.
REQ-034 SHALL pass this scenario: rst_n pulsed low after 4 accepted samples -> all outputs are 0 asynchronously, no frame_err; the next full frame packs correctly from slot a.
